// File: rtl/inv_ip_pkg.sv
// Shared constants for the sequential modular-inverse/division engine:
// FSM encodings, operating modes and the default watchdog limit.
package inv_ip_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_INV = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Binary extended Euclid finishes well inside 2*W+1 steps; 4*W leaves headroom.
    function automatic int max_iter_f(input int w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/inv_ip_seq_if.sv
// Operand/result handshake bundle between operand fetch, the inverse engine
// and the field-arithmetic datapath.
interface inv_ip_seq_if #(
    parameter int IP_WIDTH = 6,
    parameter int CNT_W    = $clog2(inv_ip_pkg::max_iter_f(IP_WIDTH) + 1)
);

    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic [IP_WIDTH-1:0] in_prime;
    logic [IP_WIDTH-1:0] in_a;
    logic [IP_WIDTH-1:0] in_b;
    logic                out_valid;
    logic                out_ready;
    logic [IP_WIDTH-1:0] out_data;
    logic                out_err;
    logic [CNT_W-1:0]    out_iter;

    modport master (
        output in_valid, in_mode, in_prime, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_iter
    );

    modport slave (
        input  in_valid, in_mode, in_prime, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_err, out_iter
    );

endinterface

// File: rtl/inv_ip_step.sv
// One combinational step of binary extended Euclid on (u, v, x1, x2) mod p.
// The invariants a*x1 == b*u and a*x2 == b*v (mod p) are preserved.
module inv_ip_step #(
    parameter int IP_WIDTH = 6
) (
    input  logic [IP_WIDTH-1:0] u,
    input  logic [IP_WIDTH-1:0] v,
    input  logic [IP_WIDTH-1:0] x1,
    input  logic [IP_WIDTH-1:0] x2,
    input  logic [IP_WIDTH-1:0] p,
    output logic [IP_WIDTH-1:0] u_nxt,
    output logic [IP_WIDTH-1:0] v_nxt,
    output logic [IP_WIDTH-1:0] x1_nxt,
    output logic [IP_WIDTH-1:0] x2_nxt,
    output logic                term
);

    // Halve x mod odd p; the extra bit keeps the carry of x+p before the shift.
    function automatic logic [IP_WIDTH-1:0] half_mod(input logic [IP_WIDTH-1:0] x,
                                                     input logic [IP_WIDTH-1:0] m);
        logic [IP_WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[IP_WIDTH:1];
    endfunction

    // x - y mod m; the top bit of the widened difference is its sign.
    function automatic logic [IP_WIDTH-1:0] sub_mod(input logic [IP_WIDTH-1:0] x,
                                                    input logic [IP_WIDTH-1:0] y,
                                                    input logic [IP_WIDTH-1:0] m);
        logic [IP_WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[IP_WIDTH]) d = d + {1'b0, m};
        return d[IP_WIDTH-1:0];
    endfunction

    assign term = (u == IP_WIDTH'(1)) || (v == IP_WIDTH'(1)) ||
                  (u == '0) || (v == '0);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        u_nxt  = u;
        v_nxt  = v;
        x1_nxt = x1;
        x2_nxt = x2;
        if (!u[0]) begin
            u_nxt  = u >> 1;
            x1_nxt = half_mod(x1, p);
        end else if (!v[0]) begin
            v_nxt  = v >> 1;
            x2_nxt = half_mod(x2, p);
        end else if (u >= v) begin
            u_nxt  = u - v;
            x1_nxt = sub_mod(x1, x2, p);
        end else begin
            v_nxt  = v - u;
            x2_nxt = sub_mod(x2, x1, p);
        end
    end

endmodule

// File: rtl/inv_ip_seq.sv
// Multi-cycle modular inverse / division engine: one Euclid step per clock,
// valid/ready on both sides, one operation in flight.
module inv_ip_seq
    import inv_ip_pkg::*;
#(
    parameter int IP_WIDTH = 6,
    parameter int MAX_ITER = max_iter_f(IP_WIDTH),
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic         clk,
    input  logic         rst,
    inv_ip_seq_if.slave  bus
);

    logic [1:0]          state;
    logic [IP_WIDTH-1:0] u_q, v_q, x1_q, x2_q, p_q;
    logic [IP_WIDTH-1:0] u_nxt, v_nxt, x1_nxt, x2_nxt;
    logic                term;
    logic [CNT_W-1:0]    iter_q;
    logic                out_valid_q;
    logic [IP_WIDTH-1:0] out_data_q;
    logic                out_err_q;
    logic                illegal;

    inv_ip_step #(.IP_WIDTH(IP_WIDTH)) u_step (
        .u      (u_q),
        .v      (v_q),
        .x1     (x1_q),
        .x2     (x2_q),
        .p      (p_q),
        .u_nxt  (u_nxt),
        .v_nxt  (v_nxt),
        .x1_nxt (x1_nxt),
        .x2_nxt (x2_nxt),
        .term   (term)
    );

    assign illegal = !bus.in_prime[0] || (bus.in_prime < IP_WIDTH'(3)) ||
                     (bus.in_a == '0) || (bus.in_a >= bus.in_prime) ||
                     ((bus.in_mode == MODE_DIV) && (bus.in_b >= bus.in_prime));

    // Both handshake outputs come straight from state flops.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_iter  = iter_q;

    // NOTE: every datapath register is reset too, so an aborted run leaves nothing visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            state       <= ST_IDLE;
            u_q         <= '0;
            v_q         <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            p_q         <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        iter_q <= '0;
                        if (illegal) begin
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_data_q  <= '0;
                            state       <= ST_DONE;
                        end else begin
                            u_q   <= bus.in_a;
                            v_q   <= bus.in_prime;
                            x1_q  <= (bus.in_mode == MODE_DIV) ? bus.in_b : IP_WIDTH'(1);
                            x2_q  <= '0;
                            p_q   <= bus.in_prime;
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (term || (iter_q == CNT_W'(MAX_ITER))) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                        // u==1 outranks v==1, which outranks the error exits.
                        if (u_q == IP_WIDTH'(1)) begin
                            out_data_q <= x1_q;
                            out_err_q  <= 1'b0;
                        end else if (v_q == IP_WIDTH'(1)) begin
                            out_data_q <= x2_q;
                            out_err_q  <= 1'b0;
                        end else begin
                            out_data_q <= '0;
                            out_err_q  <= 1'b1;
                        end
                    end else begin
                        u_q    <= u_nxt;
                        v_q    <= v_nxt;
                        x1_q   <= x1_nxt;
                        x2_q   <= x2_nxt;
                        iter_q <= iter_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_ip_seq.sv
// Scoreboard bench for inv_ip_seq: a brute-force modular model predicts each
// result when the operand set is accepted; the monitor side pops and compares.
module tb_inv_ip_seq;
    import inv_ip_pkg::*;

    localparam int W        = 6;
    localparam int MAX_IT   = 4 * W;
    localparam int CW       = $clog2(MAX_IT + 1);
    localparam int TIMEOUT  = 100;

    typedef struct {
        string       tag;
        logic [W-1:0] data;
        logic        err;
        logic        illegal;
        int          iter;   // -1 when the step count is not predicted
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    inv_ip_seq_if #(.IP_WIDTH(W), .CNT_W(CW)) bus ();

    inv_ip_seq #(.IP_WIDTH(W), .MAX_ITER(MAX_IT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int gcd_f(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Independent reference: legality rules, gcd test, then exhaustive search for x.
    function automatic exp_t model(input string tag, input logic mode, input int p,
                                   input int a, input int b, input int iter);
        exp_t e;
        int   target;
        e.tag     = tag;
        e.data    = '0;
        e.err     = 1'b0;
        e.iter    = iter;
        e.illegal = (p % 2 == 0) || (p < 3) || (a == 0) || (a >= p) ||
                    (mode == MODE_DIV && b >= p);
        if (e.illegal) begin
            e.err  = 1'b1;
            e.iter = 0;
        end else if (gcd_f(a, p) != 1) begin
            e.err = 1'b1;
        end else begin
            target = (mode == MODE_DIV) ? b : 1;
            for (int x = 0; x < p; x++)
                if ((a * x) % p == target) e.data = W'(x);
        end
        return e;
    endfunction

    task automatic do_op(input string tag, input logic mode, input int p, input int a,
                         input int b, input int iter, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        bus.in_mode  = mode;
        bus.in_prime = W'(p);
        bus.in_a     = W'(a);
        bus.in_b     = W'(b);
        bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        @(posedge clk);
        sb_q.push_back(model(tag, mode, p, a, b, iter));
        #1 bus.in_valid = 1'b0;

        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 0, 1);
            void'(sb_q.pop_front());
            return;
        end

        e = sb_q.pop_front();
        check({e.tag, "_data"}, 32'(bus.out_data), 32'(e.data));
        check({e.tag, "_err"},  32'(bus.out_err),  32'(e.err));
        check({e.tag, "_iter_lt_max"}, 32'(bus.out_iter < CW'(MAX_IT)), 1);
        if (e.iter >= 0) check({e.tag, "_iter"}, 32'(bus.out_iter), 32'(e.iter));
        if (e.illegal) check({e.tag, "_latency"}, 32'(lat), 0);
        else           check({e.tag, "_latency"}, 32'(lat), 32'(bus.out_iter) + 1);

        // Backpressure: results must hold and a stray request must be ignored.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_prime = 6'd13;
            bus.in_a     = 6'd4;
            @(negedge clk);
            check({e.tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            check({e.tag, "_hold_data"},  32'(bus.out_data),  32'(e.data));
            check({e.tag, "_hold_err"},   32'(bus.out_err),   32'(e.err));
            check({e.tag, "_hold_ready"}, 32'(bus.in_ready),  0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check({e.tag, "_consumed"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        check({e.tag, "_idle_ready"}, 32'(bus.in_ready), 1);
        if (hold > 0) check({e.tag, "_stray_ignored"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int odd_p[22] = '{61, 59, 53, 47, 43, 37, 31, 29, 23, 19, 17, 13, 11, 7, 5, 3,
                          15, 21, 25, 45, 63, 9};
        int p, a, b;
        logic mode;

        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = MODE_INV;
        bus.in_prime  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_out_err",   32'(bus.out_err),   0);
        check("rst_out_iter",  32'(bus.out_iter),  0);

        do_op("inv_61_2",   MODE_INV, 61, 2, 0, 1, 0);
        do_op("div_61_3_5", MODE_DIV, 61, 3, 5, -1, 0);
        do_op("inv_a1",     MODE_INV, 61, 1, 0, 0, 0);
        do_op("ill_a0",     MODE_INV, 61, 0, 0, 0, 0);
        do_op("ill_a_eq_p", MODE_INV, 61, 61, 0, 0, 0);
        do_op("ill_p_even", MODE_INV, 60, 2, 0, 0, 0);
        do_op("ill_b_ge_p", MODE_DIV, 61, 3, 61, 0, 0);
        do_op("gcd_15_5",   MODE_INV, 15, 5, 0, -1, 0);
        do_op("bp_hold",    MODE_INV, 61, 2, 0, 1, 3);
        do_op("after_bp",   MODE_DIV, 53, 10, 7, -1, 0);

        // Abort a run with reset one step in; nothing may come out of it.
        @(negedge clk);
        bus.in_mode  = MODE_INV;
        bus.in_prime = 6'd61;
        bus.in_a     = 6'd59;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_out_data",  32'(bus.out_data),  0);
        check("abort_out_err",   32'(bus.out_err),   0);
        check("abort_out_iter",  32'(bus.out_iter),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_output", 32'(bus.out_valid), 0);
        do_op("inv_61_59", MODE_INV, 61, 59, 0, 2, 0);

        for (int i = 0; i < 20; i++) begin
            p    = odd_p[$urandom_range(21, 0)];
            a    = $urandom_range(p - 1, 1);
            b    = $urandom_range(p - 1, 0);
            mode = 1'($urandom_range(1, 0));
            do_op($sformatf("rnd%0d_p%0d_a%0d_b%0d_m%0d", i, p, a, b, mode),
                  mode, p, a, b, -1, (i % 5 == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
